// File: rtl/audio_interp.sv
// Audio conditioning stage: linear ramp between successive samples over 2^K clocks,
// optional LFSR dither, and saturation to an A-bit signed word for the FM modulator.
module audio_interp #(
   parameter int          A         = 8,
   parameter int          K         = 6,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [A-1:0] din,
   input  logic                din_valid,
   input  logic        [2:0]   dith_fact,
   output logic signed [A-1:0] dout,
   output logic                ramp_active
);

   localparam int W = A + K;

   typedef enum logic {IDLE, RAMP} state_t;

   state_t              state, state_nx;
   logic signed [W-1:0] acc, acc_nx;
   logic signed [W-1:0] target, target_nx;
   logic signed [W-1:0] step, step_nx;
   logic        [K-1:0] cnt, cnt_nx;
   logic        [15:0]  lfsr;
   logic                lfsr_fb;

   logic signed [W-1:0] din_target;
   logic signed [W:0]   diff;
   logic signed [W-1:0] step_load;
   logic signed [7:0]   lfsr_hi;
   logic signed [7:0]   dth8;
   logic        [3:0]   dth_shamt;
   logic signed [W:0]   dth;
   logic signed [W:0]   sum;
   logic signed [W:0]   sum_sh;
   logic                sat_ovf;
   logic signed [A-1:0] dout_nx;

   // Step is the rounded-down slope from the current acc to the new target;
   // the extra bit keeps a full-scale swing from overflowing the difference.
   assign din_target = $signed({din, {K{1'b0}}});
   assign diff       = $signed({din_target[W-1], din_target}) - $signed({acc[W-1], acc});
   assign step_load  = W'(diff >>> K);

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_nx  = state;
      acc_nx    = acc;
      target_nx = target;
      step_nx   = step;
      cnt_nx    = cnt;
      if (din_valid) begin
         target_nx = din_target;
         step_nx   = step_load;
         cnt_nx    = '1;
         state_nx  = RAMP;
      end else if (state == RAMP) begin
         if (cnt != '0) begin
            acc_nx = acc + step;
            cnt_nx = cnt - K'(1);
         end else begin
            acc_nx   = target;
            state_nx = IDLE;
         end
      end
   end

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Dither lives in the fraction bits of acc; amplitude 0 must be exactly zero,
   // not the -1/0 an 8-bit arithmetic shift would leave behind.
   assign lfsr_hi   = $signed(lfsr[15:8]);
   assign dth_shamt = 4'd8 - {1'b0, dith_fact};
   assign dth8      = (dith_fact == 3'd0) ? 8'sd0 : (lfsr_hi >>> dth_shamt);
   assign dth       = $signed({{(W + 1 - 8){dth8[7]}}, dth8});

   assign sum     = $signed({acc[W-1], acc}) + dth;
   assign sum_sh  = sum >>> K;
   assign sat_ovf = !((&sum_sh[W:A-1]) || !(|sum_sh[W:A-1]));
   assign dout_nx = sat_ovf ? $signed({sum_sh[W], {(A - 1){~sum_sh[W]}}}) : sum_sh[A-1:0];

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the values sampled at the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         target <= '0;
         step   <= '0;
         cnt    <= '0;
         lfsr   <= LFSR_SEED;
         dout   <= '0;
      end else begin
         state  <= state_nx;
         acc    <= acc_nx;
         target <= target_nx;
         step   <= step_nx;
         cnt    <= cnt_nx;
         lfsr   <= {lfsr[14:0], lfsr_fb};
         dout   <= dout_nx;
      end
   end

   assign ramp_active = (state == RAMP);

endmodule

// File: tb/tb_audio_interp.sv
// Directed bench for audio_interp (A=8, K=6): reset, ramps up/down, retrigger,
// full-scale swing, dither bounds and the zero-step ramp.
module tb_audio_interp;

   logic              clk;
   logic              rst_n;
   logic signed [7:0] din;
   logic              din_valid;
   logic        [2:0] dith_fact;
   logic signed [7:0] dout;
   logic              ramp_active;

   int checks = 0;
   int errors = 0;

   audio_interp #(.A(8), .K(6), .LFSR_SEED(16'hACE1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .dith_fact   (dith_fact),
      .dout        (dout),
      .ramp_active (ramp_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_in(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s observed %0d expected range %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the load edge.
   task automatic load(input logic signed [7:0] v);
      din       = v;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   initial begin
      int exp_v;
      rst_n     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      dith_fact = 3'd0;
      repeat (3) @(negedge clk);
      check("reset_dout", dout, 0);
      check("reset_ramp", ramp_active, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: reset in the middle of a ramp
      load(8'sd100);
      repeat (5) @(negedge clk);
      check("t1_pre_ramp", ramp_active, 1);
      check("t1_pre_dout", dout, 6);
      rst_n = 1'b0;
      #1;
      check("t1_async_dout", dout, 0);
      check("t1_async_ramp", ramp_active, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t1_idle_dout", dout, 0);
         check("t1_idle_ramp", ramp_active, 0);
      end

      // T2: ramp 0 -> 64, one LSB per clock
      load(8'sd64);
      check("t2_load_ramp", ramp_active, 1);
      check("t2_load_dout", dout, 0);
      for (int k = 1; k <= 65; k++) begin
         @(negedge clk);
         check("t2_dout", dout, k - 1);
         check("t2_ramp", ramp_active, (k <= 63) ? 1 : 0);
      end
      repeat (3) @(negedge clk);
      check("t2_hold", dout, 64);

      // T3: ramp 64 -> -64, two LSBs per clock
      load(-8'sd64);
      for (int k = 1; k <= 65; k++) begin
         @(negedge clk);
         exp_v = (k == 65) ? -64 : 64 - 2 * (k - 1);
         check("t3_dout", dout, exp_v);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_hold", dout, -64);
      end

      // T4: retrigger toward 0 ten clocks into a ramp to 64
      load(8'sd0);
      repeat (70) @(negedge clk);
      check("t4_start", dout, 0);
      load(8'sd64);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         check("t4_up", dout, k - 1);
      end
      load(8'sd0);
      check("t4_peak", dout, 9);
      check("t4_retrig_ramp", ramp_active, 1);
      for (int m = 1; m <= 65; m++) begin
         @(negedge clk);
         exp_v = (m == 65) ? 0 : (576 - 9 * (m - 1)) / 64;
         check("t4_down", dout, exp_v);
      end
      check("t4_end_ramp", ramp_active, 0);

      // T6: full-scale swing -128 -> 127
      load(-8'sd128);
      repeat (70) @(negedge clk);
      check("t6_start", dout, -128);
      load(8'sd127);
      for (int k = 1; k <= 65; k++) begin
         @(negedge clk);
         exp_v = (k == 65) ? 127 : ((-8192 + 255 * (k - 1)) >>> 6);
         check("t6_dout", dout, exp_v);
      end

      // T5: dither at full-scale positive input
      dith_fact = 3'd7;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check_in("t5_dith7", dout, 126, 127);
      end
      dith_fact = 3'd0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t5_dith0", dout, 127);
      end
      dith_fact = 3'd1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check_in("t5_dith1", dout, 126, 127);
      end
      dith_fact = 3'd0;
      @(negedge clk);

      // Zero-step ramp: target equals acc, ramp still runs its full length
      load(8'sd127);
      for (int k = 1; k <= 66; k++) begin
         @(negedge clk);
         check("eq_dout", dout, 127);
         check("eq_ramp", ramp_active, (k <= 63) ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
